// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b memory-side types and the line-address helper used by the pmem arbiter.
// Line size and the default starvation bound live here so L2, EWB and arbiter agree.
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int LC3B_LINE_OFFSET_BITS = 4;
  localparam int PMEM_ARB_STARVE_LIMIT = 4;

  // True when both byte addresses fall in the same cache line.
  function automatic logic same_line(
    input lc3b_word a,
    input lc3b_word b,
    input int       offset_bits
  );
    return (a >> offset_bits) == (b >> offset_bits);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of read grants made while a writeback was waiting.
// sat tells the arbiter the pending write must win the next arbitration.
module arb_starve_counter
  import pmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = PMEM_ARB_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clr wins over inc; the two are never requested together by the arbiter.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pmem_arbiter.sv
// Single-port physical-memory arbiter between L2 line fills and EWB writebacks.
// Reads win unless the write is starved or targets the line the read wants.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = PMEM_ARB_STARVE_LIMIT,
  parameter int OFFSET_BITS  = LC3B_LINE_OFFSET_BITS
) (
  input  logic     clk,
  input  logic     rst,

  input  logic     l2_read,
  input  lc3b_word l2_addr,
  output logic     l2_resp,
  output lc3b_line l2_rdata,

  input  logic     ewb_write,
  input  lc3b_word ewb_addr,
  input  lc3b_line ewb_wdata,
  output logic     ewb_resp,

  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp,

  output logic     busy
);

  // Handshake: a requester raises l2_read/ewb_write and holds it, with address
  // and data stable, until its one-cycle resp pulse; pmem holds its strobe the
  // same way until pmem_resp. A grant is only made from IDLE, so every
  // transaction is separated from the next by at least one IDLE cycle.

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SERVE_READ  = 2'd1,
    ST_SERVE_WRITE = 2'd2
  } pmem_arb_state_t;

  pmem_arb_state_t state_q;
  pmem_arb_state_t state_d;

  logic grant_read;
  logic grant_write;
  logic starve_sat;
  logic line_hazard;

  assign line_hazard = same_line(l2_addr, ewb_addr, OFFSET_BITS);

  // Next-state and arbitration.
  always_comb begin
    state_d     = state_q;
    grant_read  = 1'b0;
    grant_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (l2_read && ewb_write) begin
          if (starve_sat || line_hazard) begin
            grant_write = 1'b1;
          end else begin
            grant_read  = 1'b1;
          end
        end else if (l2_read) begin
          grant_read = 1'b1;
        end else if (ewb_write) begin
          grant_write = 1'b1;
        end

        if (grant_write) begin
          state_d = ST_SERVE_WRITE;
        end else if (grant_read) begin
          state_d = ST_SERVE_READ;
        end
      end

      ST_SERVE_READ: begin
        if (pmem_resp) begin
          state_d = ST_IDLE;
        end
      end

      ST_SERVE_WRITE: begin
        if (pmem_resp) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are a function of the registered state and the live inputs.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = ewb_wdata;
    l2_resp      = 1'b0;
    ewb_resp     = 1'b0;

    case (state_q)
      ST_SERVE_READ: begin
        pmem_read    = 1'b1;
        pmem_address = l2_addr;
        l2_resp      = pmem_resp;
      end

      ST_SERVE_WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = ewb_addr;
        ewb_resp     = pmem_resp;
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only reads that jump ahead of a waiting write count toward starvation.
  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant_read && ewb_write),
    .clr (grant_write),
    .sat (starve_sat)
  );

  assign busy     = (state_q != ST_IDLE);
  assign l2_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios then randomized traffic, checked
// cycle by cycle against a transaction-level model and a read-data queue.
module tb_pmem_arbiter;

  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         l2_read;
  logic [15:0]  l2_addr;
  logic         l2_resp;
  logic [127:0] l2_rdata;
  logic         ewb_write;
  logic [15:0]  ewb_addr;
  logic [127:0] ewb_wdata;
  logic         ewb_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;

  pmem_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .OFFSET_BITS  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .l2_read      (l2_read),
    .l2_addr      (l2_addr),
    .l2_resp      (l2_resp),
    .l2_rdata     (l2_rdata),
    .ewb_write    (ewb_write),
    .ewb_addr     (ewb_addr),
    .ewb_wdata    (ewb_wdata),
    .ewb_resp     (ewb_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // pmem memory seen by the DUT, and the reference copy kept by the model
  logic [127:0] pm_mem  [0:4095];
  logic [127:0] ref_mem [0:4095];
  int           pm_cnt;
  int           pm_lat;

  // requester queues and scoreboard
  logic [15:0]  l2_q[$];
  logic [15:0]  ewb_aq[$];
  logic [127:0] ewb_dq[$];
  logic [127:0] exp_q[$];
  logic [7:0]   obs_kind[$];
  int           obs_cyc[$];

  // reference model: 0 = no transaction, 1 = fill in flight, 2 = writeback in flight
  int ref_kind, ref_next;
  int ref_starve, ref_starve_next;

  logic         l2_done, ewb_done;
  int           rst_req;
  bit           rand_gate;
  bit           raise_on_wresp;
  logic [15:0]  raise_addr;
  int           l2_raise_cyc, l2_resp_cyc, ewb_resp_cnt;
  logic [127:0] last_rdata;
  logic         prev_rd, prev_wr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: pmem model, then request driver, then checks and model update.
  task automatic step();
    @(posedge clk);
    cyc++;
    ref_kind   = ref_next;
    ref_starve = ref_starve_next;
    #1;
    if (rst) begin
      pm_cnt    = 0;
      pmem_resp = 1'b0;
    end else if (pmem_read || pmem_write) begin
      pm_cnt++;
      pmem_resp  = (pm_cnt == pm_lat + 1);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (pmem_resp && pmem_read)  pmem_rdata = pm_mem[pmem_address[15:4]];
      if (pmem_resp && pmem_write) pm_mem[pmem_address[15:4]] = pmem_wdata;
    end else begin
      pm_cnt    = 0;
      pmem_resp = 1'b0;
    end
    #1;
    if (rst_req > 0) begin
      rst       = 1'b1;
      rst_req--;
      l2_read   = 1'b0;
      ewb_write = 1'b0;
      l2_done   = 1'b0;
      ewb_done  = 1'b0;
      l2_q.delete();
      ewb_aq.delete();
      ewb_dq.delete();
    end else begin
      rst = 1'b0;
      if (l2_done)  begin l2_read   = 1'b0; l2_done  = 1'b0; end
      if (ewb_done) begin ewb_write = 1'b0; ewb_done = 1'b0; end
      if (raise_on_wresp && pmem_resp && pmem_write) begin
        l2_read        = 1'b1;
        l2_addr        = raise_addr;
        raise_on_wresp = 1'b0;
        l2_raise_cyc   = cyc;
      end else if (!l2_read && l2_q.size() > 0 && (!rand_gate || $urandom_range(0, 2) != 0)) begin
        l2_read      = 1'b1;
        l2_addr      = l2_q.pop_front();
        l2_raise_cyc = cyc;
      end
      if (!ewb_write && ewb_aq.size() > 0 && (!rand_gate || $urandom_range(0, 2) != 0)) begin
        ewb_write = 1'b1;
        ewb_addr  = ewb_aq.pop_front();
        ewb_wdata = ewb_dq.pop_front();
      end
      if (rand_gate && !l2_read)  l2_addr = 16'($urandom);
      if (rand_gate && !ewb_write) begin
        ewb_addr  = 16'($urandom);
        ewb_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    @(negedge clk);
    if (!rst) begin
      chk("busy",       busy,       ref_kind != 0);
      chk("pmem_read",  pmem_read,  ref_kind == 1);
      chk("pmem_write", pmem_write, ref_kind == 2);
      chk("pmem_addr",  pmem_address,
          (ref_kind == 1) ? l2_addr : (ref_kind == 2) ? ewb_addr : 16'h0);
      chk("pmem_wdata", pmem_wdata, ewb_wdata);
      chk("l2_resp",    l2_resp,    (ref_kind == 1) && pmem_resp);
      chk("ewb_resp",   ewb_resp,   (ref_kind == 2) && pmem_resp);
      if (pmem_read)  chk("l2_read_held",   l2_read,   1'b1);
      if (pmem_write) chk("ewb_write_held", ewb_write, 1'b1);
      if (l2_resp) begin
        l2_resp_cyc = cyc;
        last_rdata  = l2_rdata;
        l2_done     = 1'b1;
        if (exp_q.size() == 0) chk("l2_resp_unexpected", l2_resp, 1'b0);
        else                   chk("l2_rdata", l2_rdata, exp_q.pop_front());
      end
      if (ewb_resp) begin
        ewb_resp_cnt++;
        ewb_done = 1'b1;
      end
      if (pmem_read && !prev_rd)  begin obs_kind.push_back("R"); obs_cyc.push_back(cyc); end
      if (pmem_write && !prev_wr) begin obs_kind.push_back("W"); obs_cyc.push_back(cyc); end
    end
    prev_rd = pmem_read;
    prev_wr = pmem_write;

    ref_next        = ref_kind;
    ref_starve_next = ref_starve;
    if (rst) begin
      ref_next        = 0;
      ref_starve_next = 0;
      exp_q.delete();
    end else if (ref_kind == 0) begin
      if (ewb_write && (!l2_read || ref_starve == LIMIT || l2_addr[15:4] == ewb_addr[15:4])) begin
        ref_next        = 2;
        ref_starve_next = 0;
      end else if (l2_read) begin
        ref_next = 1;
        exp_q.push_back(ref_mem[l2_addr[15:4]]);
        if (ewb_write) ref_starve_next = (ref_starve < LIMIT) ? ref_starve + 1 : LIMIT;
      end
    end else if (pmem_resp) begin
      if (ref_kind == 2) ref_mem[ewb_addr[15:4]] = ewb_wdata;
      ref_next = 0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((l2_q.size() > 0 || ewb_aq.size() > 0 || l2_read || ewb_write ||
            ref_kind != 0 || raise_on_wresp) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1'b1);
    step();
  endtask

  task automatic clear_logs();
    obs_kind.delete();
    obs_cyc.delete();
    ewb_resp_cnt = 0;
  endtask

  task automatic check_order(input string tag, input string exp);
    chk({tag, "_count"}, obs_kind.size(), exp.len());
    for (int i = 0; i < obs_kind.size() && i < exp.len(); i++) begin
      chk({tag, "_order"}, obs_kind[i], exp[i]);
    end
  endtask

  task automatic push_write(input logic [15:0] a, input logic [127:0] d);
    ewb_aq.push_back(a);
    ewb_dq.push_back(d);
  endtask

  initial begin
    logic [127:0] hz_data;
    rst = 1'b1; l2_read = 1'b0; l2_addr = '0; ewb_write = 1'b0; ewb_addr = '0;
    ewb_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    pm_cnt = 0; pm_lat = 2; rst_req = 2; rand_gate = 0; raise_on_wresp = 0;
    raise_addr = '0; l2_done = 0; ewb_done = 0; prev_rd = 0; prev_wr = 0;
    ref_kind = 0; ref_next = 0; ref_starve = 0; ref_starve_next = 0;
    l2_raise_cyc = 0; l2_resp_cyc = 0; ewb_resp_cnt = 0; last_rdata = '0;
    for (int i = 0; i < 4096; i++) begin
      pm_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = pm_mem[i];
    end

    // power-up reset
    repeat (3) step();
    chk("por_busy",  busy,         1'b0);
    chk("por_rd",    pmem_read,    1'b0);
    chk("por_wr",    pmem_write,   1'b0);
    chk("por_addr",  pmem_address, 16'h0);

    // reset in the middle of a fill
    pm_lat = 10;
    l2_q.push_back(16'h0550);
    repeat (4) step();
    chk("pre_rst_busy", busy, 1'b1);
    rst_req = 2;
    repeat (3) step();
    chk("rst_busy",    busy,      1'b0);
    chk("rst_rd",      pmem_read, 1'b0);
    chk("rst_wr",      pmem_write,1'b0);
    chk("rst_l2_resp", l2_resp,   1'b0);
    step();
    chk("rst_idle_after", busy, 1'b0);

    // lone fill, latency 3
    pm_lat = 3;
    clear_logs();
    l2_q.push_back(16'h1230);
    wait_done("lone_read", 60);
    check_order("lone_read", "R");
    if (obs_cyc.size() > 0) chk("lone_read_grant_cyc", obs_cyc[0], l2_raise_cyc + 1);
    chk("lone_read_resp_cyc", l2_resp_cyc, l2_raise_cyc + 4);
    chk("lone_read_data", last_rdata, pm_mem[12'h123]);

    // both requested, different lines, no starvation: read first
    pm_lat = 1;
    clear_logs();
    l2_q.push_back(16'h2000);
    push_write(16'h3000, {$urandom, $urandom, $urandom, $urandom});
    wait_done("both", 60);
    check_order("both", "RW");

    // same-line hazard: write first, read sees the new line
    clear_logs();
    hz_data = {$urandom, $urandom, $urandom, $urandom};
    l2_q.push_back(16'h4A06);
    push_write(16'h4A00, hz_data);
    wait_done("hazard", 60);
    check_order("hazard", "WR");
    chk("hazard_data", last_rdata, hz_data);

    // starvation: five back-to-back fills over one waiting writeback
    clear_logs();
    for (int i = 0; i < 5; i++) l2_q.push_back(16'h5000 + 16'(i * 16));
    push_write(16'h6000, {$urandom, $urandom, $urandom, $urandom});
    wait_done("starve", 120);
    check_order("starve", "RRRRWR");

    // fill raised in the writeback's completion cycle
    pm_lat = 2;
    clear_logs();
    push_write(16'h7000, {$urandom, $urandom, $urandom, $urandom});
    raise_addr     = 16'h7100;
    raise_on_wresp = 1'b1;
    wait_done("wr_rd", 60);
    check_order("wr_rd", "WR");
    chk("wr_rd_ewb_resp_cycles", ewb_resp_cnt, 1);
    if (obs_cyc.size() > 1) chk("wr_rd_bubble", obs_cyc[1], obs_cyc[0] + pm_lat + 2);

    // randomized traffic over a few lines to provoke hazards and starvation
    rand_gate = 1'b1;
    for (int r = 0; r < 4; r++) begin
      pm_lat = $urandom_range(0, 4);
      for (int i = 0; i < 40; i++)
        l2_q.push_back({4'h8, 6'h00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))});
      for (int i = 0; i < 30; i++)
        push_write({4'h8, 6'h00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))},
                   {$urandom, $urandom, $urandom, $urandom});
      wait_done("rand", 6000);
    end
    chk("rand_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
